// File: rtl/cia_sp_partner.sv
// Device-side partner for the 6526 CIA serial port (SP/CNT pair).
//
// Receive (dir=0): the CIA drives CNT and SP. SP is sampled MSB first on
// each synchronized CNT rising edge, and whole bytes are presented on rx_data
// with a single-cycle rx_valid pulse. If a partial byte stalls for TIMEOUT
// cycles, or dir rises, that partial byte is dropped and rx_err pulses.
//
// Transmit (dir=1): this block drives CNT and SP. Each accepted byte is
// shifted out MSB first. A bit is set up while CNT is low and is sampled by
// the CIA on the CNT rising edge.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   dir               0 = receive, 1 = transmit (applied only while tx idle)
//   cnt_in, sp_in     CNT/SP lines from the CIA (asynchronous)
//   cnt_out, sp_out   CNT/SP values driven by this block
//   cnt_oe, sp_oe     output enables for cnt_out/sp_out
//   tx_data/valid     byte to send, valid/ready handshake with tx_ready
//   rx_data           last received byte; rx_valid and rx_err are 1-cycle pulses
module cia_sp_partner #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dir,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out,
    output logic       cnt_oe,
    output logic       sp_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StLow, StHigh} tx_state_e;

    // Synchronizers, preset to the idle-high line level
    logic cnt_s1_q, cnt_s2_q, cnt_prev_q;
    logic sp_s1_q, sp_s2_q;
    logic cnt_rise;

    tx_state_e       state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            cnt_out_q, cnt_out_d;
    logic            sp_out_q, sp_out_d;
    logic            oe_q, oe_d;
    logic            tx_accept, div_done;

    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [2:0]      rx_cnt_q, rx_cnt_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;
    logic            rx_active;

    assign cnt_rise  = cnt_s2_q & ~cnt_prev_q;
    assign tx_ready  = (state_q == StIdle) & dir & ~reset;
    assign tx_accept = tx_valid & tx_ready;
    assign div_done  = (div_q == DivLast);
    assign rx_active = ~dir & (state_q == StIdle);

    // Transmit FSM: SETUP, then 8 x (LOW, HIGH), with each phase CLK_DIV cycles long
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        cnt_out_d  = cnt_out_q;
        sp_out_d   = sp_out_q;
        oe_d       = oe_q;
        unique case (state_q)
            StIdle: begin
                // Enables follow dir here, so they fall one cycle after IDLE is reached
                oe_d      = dir;
                cnt_out_d = 1'b1;
                if (tx_accept) begin
                    state_d    = StSetup;
                    div_d      = '0;
                    bit_d      = '0;
                    tx_shift_d = tx_data;
                    sp_out_d   = tx_data[7];
                end
            end
            StSetup: begin
                oe_d = 1'b1;
                if (div_done) begin
                    div_d     = '0;
                    state_d   = StLow;
                    cnt_out_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StLow: begin
                if (div_done) begin
                    div_d     = '0;
                    state_d   = StHigh;
                    cnt_out_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHigh: begin
                if (div_done) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StIdle;
                    end else begin
                        // The next bit goes out on the same edge as the falling edge of CNT
                        state_d    = StLow;
                        cnt_out_d  = 1'b0;
                        bit_d      = bit_q + 1'b1;
                        sp_out_d   = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Receiver: shift on CNT rising edges; drop a stalled or interrupted partial byte
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        tmr_d      = tmr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (!rx_active) begin
            rx_cnt_d = '0;
            tmr_d    = '0;
            rx_err_d = (rx_cnt_q != 3'd0);
        end else if (cnt_rise) begin
            // If an edge arrives on the cycle the timeout expires, the edge takes priority
            rx_shift_d = {rx_shift_q[6:0], sp_s2_q};
            rx_cnt_d   = rx_cnt_q + 1'b1;
            tmr_d      = '0;
            if (rx_cnt_q == 3'd7) begin
                rx_data_d  = {rx_shift_q[6:0], sp_s2_q};
                rx_valid_d = 1'b1;
            end
        end else if (rx_cnt_q != 3'd0) begin
            if (tmr_q == TmrLast) begin
                rx_cnt_d = '0;
                tmr_d    = '0;
                rx_err_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end else begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_s1_q   <= 1'b1;
            cnt_s2_q   <= 1'b1;
            cnt_prev_q <= 1'b1;
            sp_s1_q    <= 1'b1;
            sp_s2_q    <= 1'b1;
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            cnt_out_q  <= 1'b1;
            sp_out_q   <= 1'b1;
            oe_q       <= 1'b0;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            tmr_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            cnt_s1_q   <= cnt_in;
            cnt_s2_q   <= cnt_s1_q;
            cnt_prev_q <= cnt_s2_q;
            sp_s1_q    <= sp_in;
            sp_s2_q    <= sp_s1_q;
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            cnt_out_q  <= cnt_out_d;
            sp_out_q   <= sp_out_d;
            oe_q       <= oe_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            tmr_q      <= tmr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign cnt_out  = cnt_out_q;
    assign sp_out   = sp_out_q;
    assign cnt_oe   = oe_q;
    assign sp_oe    = oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule
